// File: rtl/hawk_lkup_arb_if.sv
// Hawk lookup arbiter bus: requester handshakes, page read manager lookup port and responses.
// master = requesters / page read manager side, slave = arbiter.
interface hawk_lkup_arb_if #(
    parameter int unsigned ADDR_W = 40
);
    localparam int unsigned PN_W = ADDR_W - 12;

    logic                init_done;
    logic [2:0]          req_valid;
    logic [3*PN_W-1:0]   req_hppa;
    logic [2:0]          req_zero_blk;
    logic [2:0]          req_ready;
    logic                pgrd_mngr_ready;
    logic                lkup_valid;
    logic [PN_W-1:0]     lkup_hppa;
    logic                lkup_zero_blk;
    logic                trnsl_valid;
    logic [PN_W-1:0]     trnsl_ppa;
    logic [2:0]          rsp_valid;
    logic [PN_W-1:0]     rsp_ppa;
    logic                rsp_err;
    logic [2:0]          arb_state;

    modport master (
        output init_done, req_valid, req_hppa, req_zero_blk, pgrd_mngr_ready,
        output trnsl_valid, trnsl_ppa,
        input  req_ready, lkup_valid, lkup_hppa, lkup_zero_blk,
        input  rsp_valid, rsp_ppa, rsp_err, arb_state
    );

    modport slave (
        input  init_done, req_valid, req_hppa, req_zero_blk, pgrd_mngr_ready,
        input  trnsl_valid, trnsl_ppa,
        output req_ready, lkup_valid, lkup_hppa, lkup_zero_blk,
        output rsp_valid, rsp_ppa, rsp_err, arb_state
    );
endinterface

// File: rtl/hawk_lkup_arb.sv
// Round-robin arbiter sharing the page read manager ATT lookup port between cpu rd, cpu wr, cmd.
// Optional lookup watchdog enabled by defining HAWK_LKUP_TIMEOUT_EN.
module hawk_lkup_arb #(
    parameter int unsigned ADDR_W  = 40,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    hawk_lkup_arb_if.slave bus
);
    localparam int unsigned PN_W = ADDR_W - 12;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArb   = 3'd1,
        StIssue = 3'd2,
        StWait  = 3'd3,
        StResp  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [1:0]      winner_q, winner_d;
    logic [PN_W-1:0] hppa_q, hppa_d;
    logic            zero_blk_q, zero_blk_d;
    logic [2:0]      rsp_valid_q, rsp_valid_d;
    logic [PN_W-1:0] rsp_ppa_q, rsp_ppa_d;
    logic            rsp_err_q, rsp_err_d;

    logic [2:0]      req_ready;
    logic            lkup_valid;
    logic            grant_any;
    logic [1:0]      grant_idx;
    logic [1:0]      cand0, cand1, cand2;
    logic            to_expire;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Scan the three requesters starting at rr_ptr, wrapping modulo 3.
    always_comb begin
        cand0     = rr_ptr_q;
        cand1     = rr_next(cand0);
        cand2     = rr_next(cand1);
        grant_any = 1'b1;
        grant_idx = cand0;
        if (bus.req_valid[cand0]) begin
            grant_idx = cand0;
        end else if (bus.req_valid[cand1]) begin
            grant_idx = cand1;
        end else if (bus.req_valid[cand2]) begin
            grant_idx = cand2;
        end else begin
            grant_any = 1'b0;
        end
    end

`ifdef HAWK_LKUP_TIMEOUT_EN
    logic [15:0] to_cnt_q;

    // Held at zero outside WAIT so every entry into WAIT starts a fresh count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else if (state_q != StWait) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    assign to_expire = (to_cnt_q == 16'(TIMEOUT - 1));
`else
    assign to_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        winner_d    = winner_q;
        hppa_d      = hppa_q;
        zero_blk_d  = zero_blk_q;
        rsp_valid_d = '0;
        rsp_ppa_d   = rsp_ppa_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = '0;
        lkup_valid  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.init_done) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                if (grant_any) begin
                    req_ready[grant_idx] = 1'b1;
                    winner_d             = grant_idx;
                    hppa_d               = bus.req_hppa[grant_idx*PN_W +: PN_W];
                    zero_blk_d           = bus.req_zero_blk[grant_idx];
                    state_d              = StIssue;
                end
            end
            StIssue: begin
                if (bus.pgrd_mngr_ready) begin
                    lkup_valid = 1'b1;
                    state_d    = StWait;
                end
            end
            StWait: begin
                // A translation arriving on the expiry cycle still wins.
                if (bus.trnsl_valid) begin
                    rsp_valid_d = 3'b001 << winner_q;
                    rsp_ppa_d   = bus.trnsl_ppa;
                    rsp_err_d   = 1'b0;
                    state_d     = StResp;
                end else if (to_expire) begin
                    rsp_valid_d = 3'b001 << winner_q;
                    rsp_ppa_d   = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                rr_ptr_d = rr_next(winner_q);
                state_d  = StArb;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            hppa_q      <= '0;
            zero_blk_q  <= 1'b0;
            rsp_valid_q <= '0;
            rsp_ppa_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            winner_q    <= winner_d;
            hppa_q      <= hppa_d;
            zero_blk_q  <= zero_blk_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ppa_q   <= rsp_ppa_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.lkup_valid    = lkup_valid;
    assign bus.lkup_hppa     = hppa_q;
    assign bus.lkup_zero_blk = zero_blk_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_ppa       = rsp_ppa_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.arb_state     = state_q;
endmodule

// File: tb/tb_hawk_lkup_arb.sv
// Self-checking bench for hawk_lkup_arb: vector table of single lookups, scoreboarded responses,
// plus hand sequences for idle/init, stall, wait/reset and round-robin fairness.
module tb_hawk_lkup_arb;
    localparam int unsigned ADDR_W  = 40;
    localparam int unsigned PN_W    = ADDR_W - 12;
    localparam int unsigned TIMEOUT = 8;
`ifdef HAWK_LKUP_TIMEOUT_EN
    localparam int WaitHold = 5;
`else
    localparam int WaitHold = 20;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    hawk_lkup_arb_if #(.ADDR_W(ADDR_W)) bus ();

    hawk_lkup_arb #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]      valid;
        logic [PN_W-1:0] h0;
        logic [PN_W-1:0] h1;
        logic [PN_W-1:0] h2;
        logic [2:0]      zb;
        logic [PN_W-1:0] ppa;
        logic [2:0]      exp_ready;
        logic [PN_W-1:0] exp_hppa;
        logic            exp_zb;
    } vec_t;

    typedef struct {
        logic [2:0]      oh;
        logic [PN_W-1:0] ppa;
        logic            err;
    } rsp_t;

    rsp_t sb[$];
    vec_t tbl[8];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Wait (bounded) for a response, then compare it against the scoreboard head.
    task automatic wait_rsp(input string tag, input int exp_lat, input int limit);
        int   lat;
        rsp_t e;
        lat = 0;
        #1;
        while (bus.rsp_valid == 3'b000 && lat < limit) begin
            @(negedge clk_i);
            #1;
            lat++;
        end
        check({tag, " rsp latency"}, lat, exp_lat);
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s scoreboard: got empty queue, expected a pending response", tag);
        end else begin
            n_pass++;
            e = sb.pop_front();
            check({tag, " rsp_valid"}, bus.rsp_valid, e.oh);
            check({tag, " rsp_ppa"}, bus.rsp_ppa, e.ppa);
            check({tag, " rsp_err"}, bus.rsp_err, e.err);
        end
    endtask

    // One full lookup with pgrd_mngr_ready high and translation one cycle after lkup_valid.
    task automatic do_txn(input vec_t v, input string tag);
        @(negedge clk_i);
        bus.req_valid       = v.valid;
        bus.req_hppa        = {v.h2, v.h1, v.h0};
        bus.req_zero_blk    = v.zb;
        bus.pgrd_mngr_ready = 1'b1;
        bus.trnsl_valid     = 1'b0;
        sb.push_back('{oh: v.exp_ready, ppa: v.ppa, err: 1'b0});
        #1;
        check({tag, " state arb"}, bus.arb_state, 3'd1);
        check({tag, " rsp idle"}, bus.rsp_valid, 3'b000);
        check({tag, " req_ready"}, bus.req_ready, v.exp_ready);
        @(negedge clk_i);
        bus.req_valid = v.valid & ~v.exp_ready;
        #1;
        check({tag, " lkup_valid"}, bus.lkup_valid, 1'b1);
        check({tag, " lkup_hppa"}, bus.lkup_hppa, v.exp_hppa);
        check({tag, " lkup_zero_blk"}, bus.lkup_zero_blk, v.exp_zb);
        check({tag, " ready drop"}, bus.req_ready, 3'b000);
        @(negedge clk_i);
        bus.trnsl_valid = 1'b1;
        bus.trnsl_ppa   = v.ppa;
        #1;
        check({tag, " lkup pulse"}, {bus.lkup_valid, bus.rsp_valid}, 4'b0000);
        @(negedge clk_i);
        bus.trnsl_valid = 1'b0;
        bus.trnsl_ppa   = ~v.ppa;
        wait_rsp(tag, 0, 4);
    endtask

    // Grant requester 0 alone and observe its lookup strobe (cycles 0 and 1).
    task automatic grant_issue(input logic [PN_W-1:0] h, input string tag);
        @(negedge clk_i);
        bus.req_valid       = 3'b001;
        bus.req_hppa        = {{(2*PN_W){1'b0}}, h};
        bus.req_zero_blk    = 3'b000;
        bus.pgrd_mngr_ready = 1'b1;
        bus.trnsl_valid     = 1'b0;
        #1;
        check({tag, " req_ready"}, bus.req_ready, 3'b001);
        @(negedge clk_i);
        bus.req_valid = 3'b000;
        #1;
        check({tag, " lkup"}, {bus.lkup_valid, bus.lkup_hppa}, {1'b1, h});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        int   stay;
        vec_t v;

        //            valid   h0            h1        h2        zb      ppa           ready   hppa   zb
        tbl[0] = '{3'b001, 28'h123,      28'h0,   28'h0,   3'b000, 28'h0456,     3'b001, 28'h123,     1'b0};
        tbl[1] = '{3'b111, 28'h111,      28'h222, 28'h333, 3'b010, 28'h0AAA,     3'b010, 28'h222,     1'b1};
        tbl[2] = '{3'b011, 28'h111,      28'h222, 28'h333, 3'b001, 28'h0BBB,     3'b001, 28'h111,     1'b1};
        tbl[3] = '{3'b100, 28'h111,      28'h222, 28'h333, 3'b100, 28'h0CCC,     3'b100, 28'h333,     1'b1};
        tbl[4] = '{3'b110, 28'h111,      28'h222, 28'h333, 3'b000, 28'h0DDD,     3'b010, 28'h222,     1'b0};
        tbl[5] = '{3'b101, 28'h111,      28'h222, 28'h333, 3'b000, 28'h0EEE,     3'b100, 28'h333,     1'b0};
        tbl[6] = '{3'b111, 28'hFFFFFFF, 28'h1,   28'h2,   3'b001, 28'hFFFFFFF,  3'b001, 28'hFFFFFFF, 1'b1};
        tbl[7] = '{3'b011, 28'h5,        28'h0,   28'h7,   3'b000, 28'h0001,     3'b010, 28'h0,       1'b0};

        bus.init_done       = 1'b0;
        bus.req_valid       = 3'b111;
        bus.req_hppa        = '1;
        bus.req_zero_blk    = 3'b111;
        bus.pgrd_mngr_ready = 1'b1;
        bus.trnsl_valid     = 1'b0;
        bus.trnsl_ppa       = '1;

        // Reset and held-off init: nothing may move even with requests pending.
        @(negedge clk_i);
        #1;
        check("reset outputs", {bus.arb_state, bus.req_ready, bus.lkup_valid, bus.rsp_valid,
              bus.rsp_err, bus.lkup_zero_blk, |bus.lkup_hppa, |bus.rsp_ppa}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            #1;
            check("idle outputs", {bus.arb_state, bus.req_ready, bus.lkup_valid, bus.rsp_valid,
                  bus.rsp_err, bus.lkup_zero_blk, |bus.lkup_hppa, |bus.rsp_ppa}, 64'd0);
        end
        @(negedge clk_i);
        bus.init_done = 1'b1;
        bus.req_valid = 3'b000;
        #1;
        check("idle before init edge", bus.arb_state, 3'd0);

        for (int i = 0; i < 8; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

        // Stall: manager not ready for 5 cycles, stray translations must be ignored.
        @(negedge clk_i);
        bus.req_valid       = 3'b001;
        bus.req_hppa        = {28'h0, 28'h0, 28'h0ABCDEF};
        bus.req_zero_blk    = 3'b000;
        bus.pgrd_mngr_ready = 1'b0;
        sb.push_back('{oh: 3'b001, ppa: 28'h1234567, err: 1'b0});
        #1;
        check("stall req_ready", bus.req_ready, 3'b001);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk_i);
            bus.req_valid   = 3'b000;
            bus.trnsl_valid = (i % 2 == 0);
            bus.trnsl_ppa   = 28'h0DEAD00;
            #1;
            check("stall hold", {bus.arb_state, bus.lkup_valid, bus.rsp_valid}, {3'd2, 1'b0, 3'b000});
        end
        @(negedge clk_i);
        bus.pgrd_mngr_ready = 1'b1;
        bus.trnsl_valid     = 1'b0;
        #1;
        check("stall lkup", {bus.lkup_valid, bus.lkup_hppa}, {1'b1, 28'h0ABCDEF});
        @(negedge clk_i);
        bus.trnsl_valid = 1'b1;
        bus.trnsl_ppa   = 28'h1234567;
        #1;
        check("stall wait", {bus.arb_state, bus.lkup_valid}, {3'd3, 1'b0});
        @(negedge clk_i);
        bus.trnsl_valid = 1'b0;
        wait_rsp("stall", 0, 4);

`ifdef HAWK_LKUP_TIMEOUT_EN
        grant_issue(28'h77, "timeout");
        sb.push_back('{oh: 3'b001, ppa: 28'h0, err: 1'b1});
        @(negedge clk_i);
        wait_rsp("timeout", 8, 12);
`endif

        // Lookup never answered, then reset lands in WAIT: request is dropped silently.
        grant_issue(28'h99, "lost");
        stay = 0;
        for (int i = 0; i < WaitHold; i++) begin
            @(negedge clk_i);
            #1;
            if (bus.arb_state == 3'd3 && bus.rsp_valid == 3'b000) stay++;
        end
        check("wait hold cycles", stay, WaitHold);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("mid reset outputs", {bus.arb_state, bus.rsp_valid, bus.lkup_valid,
              |bus.lkup_hppa, |bus.rsp_ppa, bus.rsp_err}, 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Fairness from a cleared pointer: rd, wr, cmd, rd with all three held.
        for (int k = 0; k < 4; k++) begin
            v.valid     = 3'b111;
            v.h0        = 28'h0A0;
            v.h1        = 28'h0A1;
            v.h2        = 28'h0A2;
            v.zb        = 3'b000;
            v.ppa       = 28'h100 + 28'(k);
            v.exp_ready = (k == 1) ? 3'b010 : (k == 2) ? 3'b100 : 3'b001;
            v.exp_hppa  = (k == 1) ? 28'h0A1 : (k == 2) ? 28'h0A2 : 28'h0A0;
            v.exp_zb    = 1'b0;
            do_txn(v, $sformatf("rr%0d", k));
        end

        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
